// File: rtl/display_pkg.sv
// Shared state encoding and default sizing for the system-memory port arbiter.
package display_pkg;

  localparam int ADDR_W_C        = 7;
  localparam int DATA_W_C        = 8;
  localparam int LINE_WORDS_C    = 100;
  localparam int MAX_HOST_WAIT_C = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISP,
    ST_HOST,
    ST_HOST_INS,
    ST_DRAIN
  } arb_state_t;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_sat_counter #(
  parameter int WIDTH = 5,
  parameter int MAX   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != WIDTH'(MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sysmem_port_arbiter.sv
// Shares the system-memory port between display refill bursts (priority) and host single-word access.
// ARB_PERF_CNT_EN adds saturating burst/preempt counters; otherwise the perf outputs are tied to 0.
module sysmem_port_arbiter
  import display_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_C,
  parameter int DATA_W        = DATA_W_C,
  parameter int LINE_WORDS    = LINE_WORDS_C,
  parameter int MAX_HOST_WAIT = MAX_HOST_WAIT_C
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_base_i,
  output logic              disp_gnt_o,
  output logic              disp_rvalid_o,
  output logic [DATA_W-1:0] disp_rdata_o,
  output logic              disp_done_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_ack_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              sm_re_o,
  output logic              sm_we_o,
  output logic [ADDR_W-1:0] sm_addr_o,
  output logic [DATA_W-1:0] sm_wdata_o,
  input  logic [DATA_W-1:0] sm_rdata_i,
  output logic [15:0]       perf_bursts_o,
  output logic [15:0]       perf_preempts_o
);

  localparam int CNT_W  = $clog2(LINE_WORDS + 1);
  localparam int WAIT_W = $clog2(MAX_HOST_WAIT + 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              sm_re_q, sm_re_d, sm_we_q, sm_we_d;
  logic [ADDR_W-1:0] sm_addr_q, sm_addr_d;
  logic [DATA_W-1:0] sm_wdata_q, sm_wdata_d;
  logic              disp_gnt_q, disp_gnt_d;
  logic              disp_rvalid_q, disp_rvalid_d;
  logic              disp_done_q, disp_done_d;
  logic              host_ack_q, host_ack_d;
  logic              host_rd_q, host_rd_d;

  logic              host_slot, host_pend, host_wins;
  logic              go_disp_new, go_disp_next, go_host;
  logic [WAIT_W-1:0] wait_cnt;

  // A request still visible in its own ack cycle is the one just served.
  assign host_slot = (state_q == ST_HOST) || (state_q == ST_HOST_INS);
  assign host_pend = host_req_i && !host_ack_q && !host_slot;
  assign host_wins = host_pend && (wait_cnt == WAIT_W'(MAX_HOST_WAIT));

  arb_sat_counter #(.WIDTH(WAIT_W), .MAX(MAX_HOST_WAIT)) u_wait_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (host_pend),
    .clr_i (host_slot),
    .cnt_o (wait_cnt)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    base_d        = base_q;
    sm_re_d       = 1'b0;
    sm_we_d       = 1'b0;
    sm_addr_d     = sm_addr_q;
    sm_wdata_d    = sm_wdata_q;
    disp_rvalid_d = (state_q == ST_DISP);
    disp_done_d   = 1'b0;
    host_ack_d    = host_slot;
    host_rd_d     = host_slot && sm_re_q;
    go_disp_new   = 1'b0;
    go_disp_next  = 1'b0;
    go_host       = 1'b0;

    // The state register names the access on the port this cycle; the
    // output registers are loaded with the access chosen for the next one.
    case (state_q)
      ST_IDLE: begin
        if (disp_req_i && !host_wins) begin
          state_d     = ST_DISP;
          go_disp_new = 1'b1;
        end else if (host_pend) begin
          state_d = ST_HOST;
          go_host = 1'b1;
        end
      end
      ST_DISP: begin
        if (cnt_q == CNT_W'(LINE_WORDS)) begin
          state_d     = ST_DRAIN;
          disp_done_d = 1'b1;
        end else if (host_wins) begin
          state_d = ST_HOST_INS;
          go_host = 1'b1;
        end else begin
          go_disp_next = 1'b1;
        end
      end
      ST_HOST_INS: begin
        state_d      = ST_DISP;
        go_disp_next = 1'b1;
      end
      ST_HOST: begin
        if (disp_req_i) begin
          state_d     = ST_DISP;
          go_disp_new = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (host_pend) begin
          state_d = ST_HOST;
          go_host = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // cnt holds the index of the next display word to issue.
    if (go_disp_new) begin
      base_d    = disp_base_i;
      cnt_d     = CNT_W'(1);
      sm_re_d   = 1'b1;
      sm_addr_d = disp_base_i;
    end
    if (go_disp_next) begin
      cnt_d     = cnt_q + 1'b1;
      sm_re_d   = 1'b1;
      sm_addr_d = base_q + ADDR_W'(cnt_q);
    end
    if (go_host) begin
      sm_re_d    = !host_we_i;
      sm_we_d    = host_we_i;
      sm_addr_d  = host_addr_i;
      sm_wdata_d = host_wdata_i;
    end

    disp_gnt_d = (state_d == ST_DISP) || (state_d == ST_HOST_INS) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      base_q        <= '0;
      sm_re_q       <= 1'b0;
      sm_we_q       <= 1'b0;
      sm_addr_q     <= '0;
      sm_wdata_q    <= '0;
      disp_gnt_q    <= 1'b0;
      disp_rvalid_q <= 1'b0;
      disp_done_q   <= 1'b0;
      host_ack_q    <= 1'b0;
      host_rd_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      base_q        <= base_d;
      sm_re_q       <= sm_re_d;
      sm_we_q       <= sm_we_d;
      sm_addr_q     <= sm_addr_d;
      sm_wdata_q    <= sm_wdata_d;
      disp_gnt_q    <= disp_gnt_d;
      disp_rvalid_q <= disp_rvalid_d;
      disp_done_q   <= disp_done_d;
      host_ack_q    <= host_ack_d;
      host_rd_q     <= host_rd_d;
    end
  end

  assign sm_re_o       = sm_re_q;
  assign sm_we_o       = sm_we_q;
  assign sm_addr_o     = sm_addr_q;
  assign sm_wdata_o    = sm_wdata_q;
  assign disp_gnt_o    = disp_gnt_q;
  assign disp_rvalid_o = disp_rvalid_q;
  assign disp_done_o   = disp_done_q;
  assign host_ack_o    = host_ack_q;
  // Memory read data is already registered; steer it to whichever requester owns it.
  assign disp_rdata_o  = disp_rvalid_q ? sm_rdata_i : '0;
  assign host_rdata_o  = (host_ack_q && host_rd_q) ? sm_rdata_i : '0;

`ifdef ARB_PERF_CNT_EN
  arb_sat_counter #(.WIDTH(16), .MAX(65535)) u_perf_bursts (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (disp_done_q),
    .clr_i (1'b0),
    .cnt_o (perf_bursts_o)
  );

  arb_sat_counter #(.WIDTH(16), .MAX(65535)) u_perf_preempts (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (state_q == ST_HOST_INS),
    .clr_i (1'b0),
    .cnt_o (perf_preempts_o)
  );
`else
  assign perf_bursts_o   = '0;
  assign perf_preempts_o = '0;
`endif

  a_strobes_exclusive: assert property (@(posedge clk_i) disable iff (rst_i) !(sm_re_q && sm_we_q));
  a_disp_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
    ((state_q == ST_DISP) || (state_q == ST_HOST_INS)) |-> disp_req_i);

endmodule
